// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives PS/2 keyboard frames from the raw ps2 clock/data pins. The E0
//   (extended) and F0 (break) prefixes are stripped off and folded into flags.
//   Each make code produces a one-cycle scan-code pulse on o_key, and every
//   make or break produces a key event.
// Parameters
//   FILTER_LEN  : consecutive equal i_clk samples needed to accept a new ps2_clk level
//   TIMEOUT_CYC : i_clk cycles without a filtered ps2_clk edge mid-frame before abort
// Ports
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_ps2_clk      : raw PS/2 clock pin (asynchronous, idles high)
//   i_ps2_dat      : raw PS/2 data pin (asynchronous, idles high)
//   o_key          : make scan code for exactly one cycle, otherwise 8'h00
//   o_evt_valid    : one-cycle pulse when a complete make/break event is decoded
//   o_evt_code     : code of the last event, held until the next event
//   o_evt_ext      : last event carried the E0 prefix, held
//   o_evt_break    : last event carried the F0 prefix, held
//   o_frame_err    : one-cycle pulse on a parity, stop or timeout error
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_key,
  output logic       o_evt_valid,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_break,
  output logic       o_frame_err
);

  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Input path signals
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_s;
  logic             dat_s;
  logic             clk_filt;
  logic             clk_filt_d;
  logic [FLT_W-1:0] flt_cnt;
  logic             fall_c;
  logic             edge_c;

  // Receiver signals
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_c;
  logic             start_c;
  logic             shift_c;
  logic             par_ld_c;
  logic             byte_ready_c;
  logic             frame_err_c;

  // Decoder prefix flags
  logic             ext_flag;
  logic             brk_flag;

  // Two-stage synchronizers; reset to the idle-high line level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], i_ps2_clk};
      dat_sync <= {dat_sync[0], i_ps2_dat};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Glitch filter: a new clock level is accepted only after FILTER_LEN
  // consecutive samples disagree with the current filtered level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign fall_c    = clk_filt_d & ~clk_filt;
  assign edge_c    = clk_filt_d ^ clk_filt;
  assign timeout_c = (to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !edge_c;

  // Receiver state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Receiver next-state logic; a sampled edge always wins over a timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fall_c && !dat_s) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (fall_c) begin
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end else if (timeout_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PARITY: begin
        if (fall_c)         state_nxt = ST_STOP;
        else if (timeout_c) state_nxt = ST_IDLE;
      end
      ST_STOP: begin
        if (fall_c || timeout_c) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Receiver outputs: datapath strobes, byte completion and frame errors
  always_comb begin
    start_c      = 1'b0;
    shift_c      = 1'b0;
    par_ld_c     = 1'b0;
    byte_ready_c = 1'b0;
    frame_err_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        start_c = fall_c && !dat_s;
      end
      ST_DATA: begin
        shift_c     = fall_c;
        frame_err_c = timeout_c;
      end
      ST_PARITY: begin
        par_ld_c    = fall_c;
        frame_err_c = timeout_c;
      end
      ST_STOP: begin
        if (fall_c) begin
          if (dat_s && (^{shreg, par_bit})) byte_ready_c = 1'b1;
          else                              frame_err_c  = 1'b1;
        end else begin
          frame_err_c = timeout_c;
        end
      end
      default: begin
        frame_err_c = 1'b0;
      end
    endcase
  end

  // Receiver datapath: LSB-first shift register, parity bit, mid-frame timer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (start_c)      bit_cnt <= '0;
      else if (shift_c) bit_cnt <= bit_cnt + 3'd1;

      if (shift_c)  shreg   <= {dat_s, shreg[7:1]};
      if (par_ld_c) par_bit <= dat_s;

      if (state == ST_IDLE || edge_c) to_cnt <= '0;
      else if (!timeout_c)            to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Prefix decoder and registered event outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_key       <= '0;
      o_evt_valid <= 1'b0;
      o_evt_code  <= '0;
      o_evt_ext   <= 1'b0;
      o_evt_break <= 1'b0;
      o_frame_err <= 1'b0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
    end else begin
      o_key       <= '0;
      o_evt_valid <= 1'b0;
      o_frame_err <= frame_err_c;
      if (frame_err_c) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_ready_c) begin
        case (shreg)
          CODE_EXT:   ext_flag <= 1'b1;
          CODE_BRK:   brk_flag <= 1'b1;
          CODE_PAUSE: ext_flag <= ext_flag;
          default: begin
            o_evt_valid <= 1'b1;
            o_evt_code  <= shreg;
            o_evt_ext   <= ext_flag;
            o_evt_break <= brk_flag;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            if (!brk_flag) o_key <= shreg;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int unsigned FILT = 8;
  localparam int unsigned TO   = 3000;
  localparam int          HALF = 40;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_ps2_clk;
  logic       i_ps2_dat;
  logic [7:0] o_key;
  logic       o_evt_valid;
  logic [7:0] o_evt_code;
  logic       o_evt_ext;
  logic       o_evt_break;
  logic       o_frame_err;

  int total = 0;
  int bad   = 0;

  int         key_cycles = 0;
  int         evt_cnt    = 0;
  int         err_cnt    = 0;
  logic [7:0] last_key   = 8'h00;

  ps2_key_decoder #(
    .FILTER_LEN  (FILT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_dat   (i_ps2_dat),
    .o_key       (o_key),
    .o_evt_valid (o_evt_valid),
    .o_evt_code  (o_evt_code),
    .o_evt_ext   (o_evt_ext),
    .o_evt_break (o_evt_break),
    .o_frame_err (o_frame_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse monitor sampled on the falling edge
  always @(negedge i_clk) begin
    if (o_key !== 8'h00) begin
      key_cycles = key_cycles + 1;
      last_key   = o_key;
    end
    if (o_evt_valid === 1'b1) evt_cnt = evt_cnt + 1;
    if (o_frame_err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // Full frame; bad_par inverts the odd parity bit, glitch_bit (0..10) adds a
  // 3-cycle low pulse during that bit's high phase (-1 = none)
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_bit);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      i_ps2_dat = f[i];
      if (i == glitch_bit) begin
        tick(HALF / 2);
        i_ps2_clk = 1'b0;
        tick(3);
        i_ps2_clk = 1'b1;
        tick(HALF - HALF / 2 - 3);
      end else begin
        tick(HALF);
      end
      i_ps2_clk = 1'b0;
      tick(HALF);
      i_ps2_clk = 1'b1;
    end
    i_ps2_dat = 1'b1;
    tick(2 * HALF);
  endtask

  // Start bit plus the first n data bits, ending right after the last rise
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int i = 0; i <= n; i++) begin
      i_ps2_dat = f[i];
      tick(HALF);
      i_ps2_clk = 1'b0;
      tick(HALF);
      i_ps2_clk = 1'b1;
    end
    i_ps2_dat = 1'b1;
  endtask

  task automatic test_reset;
    i_rst_n   = 1'b0;
    i_ps2_clk = 1'b1;
    i_ps2_dat = 1'b1;
    tick(5);
    total++; if (o_key !== 8'h00) begin bad++; $display("FAIL reset_key: got %h want 00", o_key); end
    total++; if (o_evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_evt_valid); end
    total++; if (o_evt_code !== 8'h00) begin bad++; $display("FAIL reset_code: got %h want 00", o_evt_code); end
    total++; if ({o_evt_ext, o_evt_break, o_frame_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {o_evt_ext, o_evt_break, o_frame_err});
    end
    i_rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_ext_make;
    int k0, e0, r0;
    k0 = key_cycles; e0 = evt_cnt; r0 = err_cnt;
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    total++; if (key_cycles - k0 !== 1) begin bad++; $display("FAIL ext_make_key_cycles: got %0d want 1", key_cycles - k0); end
    total++; if (last_key !== 8'h75) begin bad++; $display("FAIL ext_make_key: got %h want 75", last_key); end
    total++; if (evt_cnt - e0 !== 1) begin bad++; $display("FAIL ext_make_evt: got %0d want 1", evt_cnt - e0); end
    total++; if (o_evt_code !== 8'h75) begin bad++; $display("FAIL ext_make_code: got %h want 75", o_evt_code); end
    total++; if ({o_evt_ext, o_evt_break} !== 2'b10) begin bad++; $display("FAIL ext_make_flags: got %b want 10", {o_evt_ext, o_evt_break}); end
    total++; if (o_key !== 8'h00) begin bad++; $display("FAIL ext_make_key_after: got %h want 00", o_key); end
    total++; if (err_cnt - r0 !== 0) begin bad++; $display("FAIL ext_make_err: got %0d want 0", err_cnt - r0); end
  endtask

  task automatic test_ext_break;
    int k0, e0;
    k0 = key_cycles; e0 = evt_cnt;
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);
    total++; if (key_cycles - k0 !== 0) begin bad++; $display("FAIL ext_break_key_cycles: got %0d want 0", key_cycles - k0); end
    total++; if (evt_cnt - e0 !== 1) begin bad++; $display("FAIL ext_break_evt: got %0d want 1", evt_cnt - e0); end
    total++; if (o_evt_code !== 8'h75) begin bad++; $display("FAIL ext_break_code: got %h want 75", o_evt_code); end
    total++; if ({o_evt_ext, o_evt_break} !== 2'b11) begin bad++; $display("FAIL ext_break_flags: got %b want 11", {o_evt_ext, o_evt_break}); end
  endtask

  task automatic test_parity_err;
    int k0, e0, r0;
    k0 = key_cycles; e0 = evt_cnt; r0 = err_cnt;
    send_frame(8'h1C, 1'b1, -1);
    total++; if (err_cnt - r0 !== 1) begin bad++; $display("FAIL parity_err_pulse: got %0d want 1", err_cnt - r0); end
    total++; if (evt_cnt - e0 !== 0) begin bad++; $display("FAIL parity_err_evt: got %0d want 0", evt_cnt - e0); end
    send_frame(8'h1C, 1'b0, -1);
    total++; if (key_cycles - k0 !== 1) begin bad++; $display("FAIL parity_ok_key_cycles: got %0d want 1", key_cycles - k0); end
    total++; if (last_key !== 8'h1C) begin bad++; $display("FAIL parity_ok_key: got %h want 1c", last_key); end
    total++; if ({o_evt_ext, o_evt_break} !== 2'b00) begin bad++; $display("FAIL parity_ok_flags: got %b want 00", {o_evt_ext, o_evt_break}); end
  endtask

  task automatic test_timeout;
    int seen, e0, k0;
    seen = -1;
    e0 = evt_cnt; k0 = key_cycles;
    send_partial(8'h6B, 4);
    // Filtered rise lands about 2+FILT cycles after the pin rise; the error
    // follows TO cycles after that
    for (int c = 0; c < int'(TO) + 40; c++) begin
      @(negedge i_clk);
      if (o_frame_err === 1'b1 && seen < 0) seen = c;
    end
    tick(1);
    total++; if (seen < int'(TO) || seen > int'(TO) + 20) begin
      bad++; $display("FAIL timeout_cycle: got %0d want %0d..%0d", seen, TO, TO + 20);
    end
    total++; if (evt_cnt - e0 !== 0) begin bad++; $display("FAIL timeout_evt: got %0d want 0", evt_cnt - e0); end
    send_frame(8'h6B, 1'b0, -1);
    total++; if (key_cycles - k0 !== 1) begin bad++; $display("FAIL timeout_next_key_cycles: got %0d want 1", key_cycles - k0); end
    total++; if (last_key !== 8'h6B) begin bad++; $display("FAIL timeout_next_key: got %h want 6b", last_key); end
  endtask

  task automatic test_glitch;
    int k0, r0;
    k0 = key_cycles; r0 = err_cnt;
    send_frame(8'h72, 1'b0, 4);
    total++; if (key_cycles - k0 !== 1) begin bad++; $display("FAIL glitch_key_cycles: got %0d want 1", key_cycles - k0); end
    total++; if (last_key !== 8'h72) begin bad++; $display("FAIL glitch_key: got %h want 72", last_key); end
    total++; if (err_cnt - r0 !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt - r0); end
  endtask

  task automatic test_back_to_back;
    int k0, e0;
    k0 = key_cycles; e0 = evt_cnt;
    send_frame(8'h1C, 1'b0, -1);
    send_frame(8'h1C, 1'b0, -1);
    total++; if (key_cycles - k0 !== 2) begin bad++; $display("FAIL repeat_key_cycles: got %0d want 2", key_cycles - k0); end
    total++; if (evt_cnt - e0 !== 2) begin bad++; $display("FAIL repeat_evt: got %0d want 2", evt_cnt - e0); end
  endtask

  task automatic test_reset_midframe;
    int k0;
    send_frame(8'hE0, 1'b0, -1);
    send_partial(8'h74, 5);
    tick(HALF);
    i_rst_n = 1'b0;
    tick(3);
    total++; if (o_key !== 8'h00) begin bad++; $display("FAIL midrst_key: got %h want 00", o_key); end
    total++; if (o_evt_code !== 8'h00) begin bad++; $display("FAIL midrst_code: got %h want 00", o_evt_code); end
    total++; if ({o_evt_valid, o_evt_ext, o_evt_break, o_frame_err} !== 4'b0000) begin
      bad++; $display("FAIL midrst_flags: got %b want 0000", {o_evt_valid, o_evt_ext, o_evt_break, o_frame_err});
    end
    i_rst_n = 1'b1;
    tick(5);
    k0 = key_cycles;
    send_frame(8'h74, 1'b0, -1);
    total++; if (key_cycles - k0 !== 1) begin bad++; $display("FAIL midrst_next_key_cycles: got %0d want 1", key_cycles - k0); end
    total++; if (last_key !== 8'h74) begin bad++; $display("FAIL midrst_next_key: got %h want 74", last_key); end
    total++; if (o_evt_ext !== 1'b0) begin bad++; $display("FAIL midrst_next_ext: got %b want 0", o_evt_ext); end
  endtask

  initial begin
    test_reset();
    test_ext_make();
    test_ext_break();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
